// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with single-word blocking fills.
// Saturating hit/miss counters are kept for performance evaluation.
module icache_direct #(
    parameter int SETS  = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic {IDLE, FETCH} state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      word;
    } frame_t;

    state_t            state, next_state;
    logic [SETS-1:0]   valid;
    frame_t            frames [SETS];
    logic [31:0]       miss_addr;
    logic              miss_start, fill;

    logic [IDX-1:0]    req_idx, miss_idx;
    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic              unused_offset;

    assign req_idx       = imemaddr[IDX+1:2];
    assign req_tag       = imemaddr[31:IDX+2];
    assign miss_idx      = miss_addr[IDX+1:2];
    assign miss_tag      = miss_addr[31:IDX+2];
    assign unused_offset = ^imemaddr[1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Hits only exist in IDLE and fills only in FETCH, so the two never collide.
    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = 32'h0;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        miss_start = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                ihit = imemREN && valid[req_idx] && (frames[req_idx].tag == req_tag);
                if (ihit) imemload = frames[req_idx].word;
                if (imemREN && !ihit) begin
                    miss_start = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid      <= '0;
            miss_addr  <= 32'h0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (miss_start) miss_addr <= imemaddr;
            if (fill) valid[miss_idx] <= 1'b1;
            if (ihit && hit_count != {CNT_W{1'b1}})
                hit_count <= hit_count + CNT_W'(1);
            if (miss_start && miss_count != {CNT_W{1'b1}})
                miss_count <= miss_count + CNT_W'(1);
        end
    end

    // Tag/data contents are qualified by valid, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (fill) frames[miss_idx] <= '{tag: miss_tag, word: iload};
    end
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct; a second instance with 3-bit counters shares stimulus.
module tb_icache_direct;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;

    logic        ihit, iREN, ihit_s, iREN_s;
    logic [31:0] imemload, iaddr, imemload_s, iaddr_s;
    logic [31:0] hit_count, miss_count;
    logic [2:0]  hit_count_s, miss_count_s;

    int n_checks = 0;
    int n_fail   = 0;

    icache_direct #(.SETS(16), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_direct #(.SETS(16), .CNT_W(3)) dut_sat (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit_s), .imemload(imemload_s), .iREN(iREN_s), .iaddr(iaddr_s),
        .iwait(iwait), .iload(iload), .hit_count(hit_count_s), .miss_count(miss_count_s)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset;
        RST = 1'b1; imemREN = 1'b0; iwait = 1'b1; iload = 32'h0; imemaddr = 32'h0;
        step();
        RST = 1'b0;
    endtask

    // Miss on addr, hold iwait high for nwait FETCH cycles, then deliver data.
    // Returns one cycle into IDLE with addr still requested.
    task automatic do_fill(input logic [31:0] addr, input int nwait, input logic [31:0] data);
        imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
        step();
        repeat (nwait) step();
        iwait = 1'b0; iload = data;
        step();
        iwait = 1'b1;
    endtask

    task automatic test_reset;
        RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0;
        @(negedge CLK);
        n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL reset_ihit got %b exp 0", ihit); end
        n_checks++; if (imemload !== 32'h0) begin n_fail++; $display("FAIL reset_imemload got %h exp 0", imemload); end
        n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL reset_iREN got %b exp 0", iREN); end
        n_checks++; if (iaddr !== 32'h0) begin n_fail++; $display("FAIL reset_iaddr got %h exp 0", iaddr); end
        n_checks++; if (hit_count !== 32'h0) begin n_fail++; $display("FAIL reset_hit_count got %0d exp 0", hit_count); end
        n_checks++; if (miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_miss_count got %0d exp 0", miss_count); end
        apply_reset();
    endtask

    task automatic test_cold_miss;
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
        @(negedge CLK);
        n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL cold_detect_ihit got %b exp 0", ihit); end
        n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL cold_detect_iREN got %b exp 0", iREN); end
        step();
        for (int i = 0; i < 4; i++) begin
            iwait = (i < 3);
            iload = (i == 3) ? 32'h8C220004 : 32'h0;
            @(negedge CLK);
            n_checks++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL cold_fetch_iREN[%0d] got %b exp 1", i, iREN); end
            n_checks++; if (iaddr !== 32'h40) begin n_fail++; $display("FAIL cold_fetch_iaddr[%0d] got %h exp 40", i, iaddr); end
            n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL cold_fetch_ihit[%0d] got %b exp 0", i, ihit); end
            step();
        end
        iwait = 1'b1;
        n_checks++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL cold_miss_count got %0d exp 1", miss_count); end
    endtask

    // The first cycle here is the cycle right after the fill edge.
    task automatic test_hit_streak;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_checks++; if (ihit !== 1'b1) begin n_fail++; $display("FAIL streak_ihit[%0d] got %b exp 1", i, ihit); end
            n_checks++; if (imemload !== 32'h8C220004) begin n_fail++; $display("FAIL streak_imemload[%0d] got %h exp 8c220004", i, imemload); end
            n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL streak_iREN[%0d] got %b exp 0", i, iREN); end
            step();
        end
        n_checks++; if (hit_count !== 32'd5) begin n_fail++; $display("FAIL streak_hit_count got %0d exp 5", hit_count); end
        n_checks++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL streak_miss_count got %0d exp 1", miss_count); end
    endtask

    task automatic test_conflict;
        apply_reset();
        do_fill(32'h04, 1, 32'h11111111);
        @(negedge CLK);
        n_checks++; if (imemload !== 32'h11111111) begin n_fail++; $display("FAIL conflict_first_load got %h exp 11111111", imemload); end
        step();
        imemaddr = 32'h44;
        @(negedge CLK);
        n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_44_ihit got %b exp 0", ihit); end
        step();
        iwait = 1'b0; iload = 32'hDEADBEEF;
        @(negedge CLK);
        n_checks++; if (iaddr !== 32'h44) begin n_fail++; $display("FAIL conflict_iaddr got %h exp 44", iaddr); end
        step();
        iwait = 1'b1;
        @(negedge CLK);
        n_checks++; if (ihit !== 1'b1 || imemload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL conflict_44_hit got %b/%h exp 1/deadbeef", ihit, imemload); end
        step();
        imemaddr = 32'h04;
        @(negedge CLK);
        n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_refetch_ihit got %b exp 0", ihit); end
        step();
        n_checks++; if (miss_count !== 32'd3) begin n_fail++; $display("FAIL conflict_miss_count got %0d exp 3", miss_count); end
        iwait = 1'b0; iload = 32'h11111111;
        step();
        iwait = 1'b1;
    endtask

    task automatic test_redirect;
        imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
        step();
        imemaddr = 32'h200;
        @(negedge CLK);
        n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h100) begin n_fail++; $display("FAIL redirect_iaddr got %b/%h exp 1/100", iREN, iaddr); end
        step();
        iwait = 1'b0; iload = 32'hAAAA0100;
        step();
        iwait = 1'b1;
        @(negedge CLK);
        n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL redirect_200_ihit got %b exp 0", ihit); end
        // Briefly look up 0x100 to confirm the fill went to the original miss address.
        imemaddr = 32'h100;
        #1;
        n_checks++; if (ihit !== 1'b1 || imemload !== 32'hAAAA0100) begin n_fail++; $display("FAIL redirect_100_hit got %b/%h exp 1/aaaa0100", ihit, imemload); end
        step();
        imemaddr = 32'h200;
        step();
        @(negedge CLK);
        n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h200) begin n_fail++; $display("FAIL redirect_refetch got %b/%h exp 1/200", iREN, iaddr); end
        step();
        iwait = 1'b0; iload = 32'hBBBB0200;
        step();
        iwait = 1'b1;
        @(negedge CLK);
        n_checks++; if (ihit !== 1'b1 || imemload !== 32'hBBBB0200) begin n_fail++; $display("FAIL redirect_200_hit got %b/%h exp 1/bbbb0200", ihit, imemload); end
        step();
    endtask

    task automatic test_reset_mid_fetch;
        do_fill(32'h40, 0, 32'h8C220004);
        imemaddr = 32'h84;
        step();
        @(negedge CLK);
        n_checks++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_iREN got %b exp 1", iREN); end
        #2;
        RST = 1'b1; iwait = 1'b0; iload = 32'hFFFFFFFF;
        #1;
        n_checks++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin n_fail++; $display("FAIL rstmid_async got %b/%h exp 0/0", iREN, iaddr); end
        n_checks++; if (miss_count !== 32'h0) begin n_fail++; $display("FAIL rstmid_miss_count got %0d exp 0", miss_count); end
        step();
        RST = 1'b0; iwait = 1'b1; imemaddr = 32'h40;
        @(negedge CLK);
        n_checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin n_fail++; $display("FAIL rstmid_40_miss got %b/%b exp 0/0", ihit, iREN); end
        step();
        @(negedge CLK);
        n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin n_fail++; $display("FAIL rstmid_refill got %b/%h exp 1/40", iREN, iaddr); end
        iwait = 1'b0; iload = 32'h8C220004;
        step();
        iwait = 1'b1; imemREN = 1'b0;
    endtask

    task automatic test_saturation;
        apply_reset();
        do_fill(32'h40, 0, 32'h8C220004);
        repeat (9) step();
        n_checks++; if (hit_count_s !== 3'd7) begin n_fail++; $display("FAIL sat_hit_count got %0d exp 7", hit_count_s); end
        n_checks++; if (hit_count !== 32'd9) begin n_fail++; $display("FAIL sat_wide_hit_count got %0d exp 9", hit_count); end
        step();
        n_checks++; if (hit_count_s !== 3'd7) begin n_fail++; $display("FAIL sat_hold got %0d exp 7", hit_count_s); end
        n_checks++; if (hit_count !== 32'd10) begin n_fail++; $display("FAIL sat_wide_hold got %0d exp 10", hit_count); end
        n_checks++; if (miss_count_s !== 3'd1) begin n_fail++; $display("FAIL sat_miss_count got %0d exp 1", miss_count_s); end
        imemREN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_streak();
        test_conflict();
        test_redirect();
        test_reset_mid_fetch();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's fetch stage (imemREN/imemaddr/ihit/imemload) and the memory controller's instruction port.
- Supplies one 32-bit word per hit cycle; on a miss it runs a single-word fill through a blocking request/wait handshake.
- Keeps saturating hit/miss counters for performance evaluation.

Parameters:
SETS, 16, number of frames; power of two, at least 2; IDX = log2(SETS).
CNT_W, 32, width of the hit and miss counters.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
imemREN  input  1  datapath instruction read request.
imemaddr  input  32  datapath byte address, word aligned.
ihit  output  1  requested word valid on imemload this cycle.
imemload  output  32  instruction word.
iREN  output  1  read request to memory controller.
iaddr  output  32  fill address to memory controller.
iwait  input  1  controller busy; low means iload is valid this cycle.
iload  input  32  fill data from memory controller.
hit_count  output  CNT_W  number of hits since reset.
miss_count  output  CNT_W  number of misses since reset.

Behaviour:
- Address split:
  - offset = imemaddr[1:0], ignored.
  - index = imemaddr[IDX+1:2].
  - tag = imemaddr[31:IDX+2].
- Storage: per frame, a valid bit, a tag of 30-IDX bits, and a 32-bit data word.
- FSM states: IDLE, FETCH.
- IDLE:
  - ihit is combinational and equals imemREN && valid[index] && tag[index]==tag.
  - imemload = data[index] whenever ihit=1; imemload = 0 otherwise.
  - iREN = 0.
  - If imemREN && !ihit, latch imemaddr into miss_addr, increment miss_count, and go to FETCH next cycle.
- FETCH:
  - iREN = 1, iaddr = miss_addr, ihit = 0, imemload = 0.
  - While iwait=1, stay in FETCH.
  - In the cycle iwait=0, on the clock edge: write data[miss_idx] = iload, tag[miss_idx] = miss_tag, valid = 1; return to IDLE.
- Fill latency:
  - Fill completes at edge N, so ihit can assert in cycle N+1 in IDLE.
  - Miss-to-hit latency = 1 (IDLE detect) + number of FETCH cycles + 1.
- Hit counting:
  - hit_count increments on every clock edge in IDLE where ihit=1, so a held address counts once per cycle.
  - Both counters saturate at all-ones and never wrap.
- imemaddr change during FETCH (branch/jump redirect):
  - The fill still completes to miss_addr.
  - IDLE then re-evaluates the new imemaddr; there is no abort.
- imemREN deasserted during FETCH: the fill completes normally; no hit is reported.
- Conflict miss: a fill overwrites the frame unconditionally; there is no write-back, since the cache is read-only.
- iaddr = 0 in IDLE.
- Reset (asynchronous; also when asserted mid-FETCH):
  - All valid bits = 0, state = IDLE, miss_addr = 0, hit_count = 0, miss_count = 0.
  - Outputs during reset: ihit = 0, imemload = 0, iREN = 0, iaddr = 0.
  - Tag and data arrays need not be reset.
  - An in-flight controller response after reset is ignored.
- Same-cycle hit and fill is impossible by construction: hits are reported only in IDLE and fills happen only in FETCH.
- Address 0x00000000 caches like any other address; there is no special case.

Test Plan:
- Cold miss:
  - Stimulus: after reset, imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0 with iload=0x8C220004.
  - Required: iREN=1 and iaddr=0x40 for 4 FETCH cycles; ihit=1 and imemload=0x8C220004 in the following cycle; miss_count=1.
- Hit streak:
  - Stimulus: hold imemaddr=0x40 for 5 more cycles.
  - Required: ihit=1 every cycle, iREN=0, hit_count=5.
- Conflict miss (SETS=16):
  - Stimulus: fill 0x00000004, then request 0x00000044 (same index 1, different tag) with iload=0xDEADBEEF.
  - Required: miss, fill, hit 0xDEADBEEF; a re-request of 0x04 misses again; miss_count=3.
- Redirect mid-fetch:
  - Stimulus: start a miss on 0x100, change imemaddr to 0x200 while iwait=1.
  - Required: fill writes the 0x100 frame; IDLE then misses on 0x200 and iaddr=0x200 in the next FETCH.
- Reset mid-fetch:
  - Stimulus: assert RST while in FETCH with iwait=1.
  - Required: iREN=0 immediately (asynchronous); after release, a request to the previously filled 0x40 misses.
- Counter saturation:
  - Stimulus: use CNT_W=3 and run 10 hit cycles.
  - Required: hit_count stops at 7 and does not wrap.
